// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared constants, MD buffer entry type and saturating-add helper
package wb_arb_pkg;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int REG_W       = 5;
  localparam int DATA_W      = 32;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } md_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, v} + {15'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - MEM/WB, MD handshake and register-file write bundle
// Stats signals exist only when WB_PORT_ARB_STATS_EN is defined.
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;

  logic [1:0]        wb_ctl;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_mem;
  logic [DATA_W-1:0] wb_alu;
  logic              md_valid;
  logic              md_ready;
  logic [REG_W-1:0]  md_rd;
  logic [DATA_W-1:0] md_data;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall_req;
`ifdef WB_PORT_ARB_STATS_EN
  logic [15:0]       stat_stall_cycles;
  logic [15:0]       stat_cancels;

  modport master (
    output wb_ctl, wb_rd, wb_mem, wb_alu, md_valid, md_rd, md_data,
    input  md_ready, rf_we, rf_waddr, rf_wdata, stall_req, stat_stall_cycles, stat_cancels
  );
  modport slave (
    input  wb_ctl, wb_rd, wb_mem, wb_alu, md_valid, md_rd, md_data,
    output md_ready, rf_we, rf_waddr, rf_wdata, stall_req, stat_stall_cycles, stat_cancels
  );
`else
  modport master (
    output wb_ctl, wb_rd, wb_mem, wb_alu, md_valid, md_rd, md_data,
    input  md_ready, rf_we, rf_waddr, rf_wdata, stall_req
  );
  modport slave (
    input  wb_ctl, wb_rd, wb_mem, wb_alu, md_valid, md_rd, md_data,
    output md_ready, rf_we, rf_waddr, rf_wdata, stall_req
  );
`endif
endinterface

// File: rtl/wb_arb_fifo.sv
// rtl/wb_arb_fifo.sv - circular MD result buffer with per-entry rd cancel
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int MD_DEPTH = 2,
  localparam int CNT_W   = $clog2(MD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [REG_W-1:0]  push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              cancel,
  input  logic [REG_W-1:0]  cancel_rd,
  output md_entry_t         head,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;

  md_entry_t        mem [MD_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MD_DEPTH; i++) mem[i] <= '0;
    end else begin
      // Stale slots may also match; clearing their live bit is harmless.
      for (int i = 0; i < MD_DEPTH; i++) begin
        if (cancel && mem[i].rd == cancel_rd) mem[i].live <= 1'b0;
      end
      if (push) begin
        mem[wr_ptr] <= '{live: 1'b1, rd: push_rd, data: push_data};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter, pipeline over buffered MD results
// Optional WB_PORT_ARB_STATS_EN adds saturating stall-cycle and cancel counters.
module wb_port_arbiter #(
  parameter int MD_DEPTH = 2,
  parameter int MAX_WAIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);
  import wb_arb_pkg::*;

  localparam int CNT_W  = $clog2(MD_DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  md_entry_t         head;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_wr, head_valid, accept, drop, push, md_wr, dead_pop, pop;

  assign pipe_wr    = bus.wb_ctl[WB_REGWRITE] && (bus.wb_rd != '0);
  assign pipe_data  = bus.wb_ctl[WB_MEMTOREG] ? bus.wb_mem : bus.wb_alu;
  assign head_valid = (count != '0);
  assign bus.md_ready = (count < CNT_W'(MD_DEPTH));

  // The pipeline write is younger than any same-rd MD result, so such results are dropped.
  assign accept   = bus.md_valid && bus.md_ready;
  assign drop     = accept && ((bus.md_rd == '0) || (pipe_wr && bus.md_rd == bus.wb_rd));
  assign push     = accept && !drop;
  assign md_wr    = !pipe_wr && head_valid && head.live;
  assign dead_pop = head_valid && !head.live;
  assign pop      = md_wr || dead_pop;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  wb_arb_fifo #(.MD_DEPTH(MD_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_rd   (bus.md_rd),
    .push_data (bus.md_data),
    .pop       (pop),
    .cancel    (pipe_wr),
    .cancel_rd (bus.wb_rd),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    wait_next = wait_cnt;
    if (count_next == '0 || md_wr)
      wait_next = '0;
    else if (head_valid && head.live && pipe_wr && wait_cnt != WAIT_W'(MAX_WAIT))
      wait_next = wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      bus.stall_req <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      bus.rf_we     <= pipe_wr || md_wr;
      wait_cnt      <= wait_next;
      bus.stall_req <= (wait_next == WAIT_W'(MAX_WAIT));
      if (pipe_wr) begin
        bus.rf_waddr <= bus.wb_rd;
        bus.rf_wdata <= pipe_data;
      end else if (md_wr) begin
        bus.rf_waddr <= head.rd;
        bus.rf_wdata <= head.data;
      end
    end
  end

`ifdef WB_PORT_ARB_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] cancels;

  assign bus.stat_stall_cycles = stall_cycles;
  assign bus.stat_cancels      = cancels;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      cancels      <= '0;
    end else begin
      stall_cycles <= sat_add16(stall_cycles, {1'b0, bus.stall_req});
      cancels      <= sat_add16(cancels, 2'(drop) + 2'(dead_pop));
    end
  end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed-vector scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.MD_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;
`ifdef WB_PORT_ARB_STATS_EN
  logic [15:0] cancels_before;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic cyc(input logic [1:0] ctl, input logic [4:0] rd, input logic [31:0] mem,
                     input logic [31:0] alu, input logic mv, input logic [4:0] mrd,
                     input logic [31:0] mdata);
    bus.wb_ctl   = ctl;
    bus.wb_rd    = rd;
    bus.wb_mem   = mem;
    bus.wb_alu   = alu;
    bus.md_valid = mv;
    bus.md_rd    = mrd;
    bus.md_data  = mdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Five back-to-back pipeline writes while the MD unit offers three results.
  task automatic fill_seq();
    logic [4:0]  mrd;
    logic [31:0] mdat;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) chk("full_md_ready", 32'(bus.md_ready), 32'd0);
      if (i == 4) chk("stall_before_max", 32'(bus.stall_req), 32'd0);
      mrd  = (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12;
      mdat = (i == 0) ? 32'hA0 : (i == 1) ? 32'hB1 : 32'hC2;
      expect_wr(5'(i + 1), 32'h100 + 32'(i));
      cyc(2'b10, 5'(i + 1), 32'h0, 32'h100 + 32'(i), 1'b1, mrd, mdat);
    end
    chk("stall_at_max", 32'(bus.stall_req), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h, no write expected",
                 bus.rf_waddr, bus.rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.rf_waddr), 32'(mon_e[36:32]));
        chk("wr_data", bus.rf_wdata, mon_e[31:0]);
      end
    end
  end

  initial begin
    bus.wb_ctl = '0; bus.wb_rd = '0; bus.wb_mem = '0; bus.wb_alu = '0;
    bus.md_valid = 1'b0; bus.md_rd = '0; bus.md_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("reset_rf_wdata", bus.rf_wdata, 32'd0);
    chk("reset_stall", 32'(bus.stall_req), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_md_ready", 32'(bus.md_ready), 32'd1);
`ifdef WB_PORT_ARB_STATS_EN
    chk("reset_stat_cancels", 32'(bus.stat_cancels), 32'd0);
`endif

    // Pipeline only: ALU then load data.
    expect_wr(5'd5, 32'h11);
    cyc(2'b10, 5'd5, 32'h0, 32'h11, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd5, 32'h22);
    cyc(2'b11, 5'd5, 32'h22, 32'h99, 1'b0, 5'd0, 32'h0);

    // MD drain in a bubble.
    expect_wr(5'd7, 32'hABCD);
    cyc(2'b00, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 32'hABCD);
    idle(3);
    chk("drain_md_ready", 32'(bus.md_ready), 32'd1);

    // Fill, backpressure, stall, then drain on bubbles.
    fill_seq();
    expect_wr(5'd10, 32'hA0);
    cyc(2'b00, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12, 32'hC2);
    chk("stall_release", 32'(bus.stall_req), 32'd0);
    expect_wr(5'd11, 32'hB1);
    cyc(2'b00, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12, 32'hC2);
    expect_wr(5'd12, 32'hC2);
    cyc(2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    idle(2);

    // Cancel: buffered rd 9 overwritten by a younger pipeline write.
`ifdef WB_PORT_ARB_STATS_EN
    cancels_before = bus.stat_cancels;
`endif
    cyc(2'b01, 5'd9, 32'h0, 32'h0, 1'b1, 5'd9, 32'hDEAD);
    expect_wr(5'd9, 32'h909);
    cyc(2'b10, 5'd9, 32'h0, 32'h909, 1'b0, 5'd0, 32'h0);
    idle(3);
`ifdef WB_PORT_ARB_STATS_EN
    chk("stat_cancel_inc", 32'(bus.stat_cancels), 32'(cancels_before) + 32'd1);
`endif

    // r0 drop, r0 pipeline write lets MD drain, same-cycle rd match drop.
    cyc(2'b00, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h55);
    idle(2);
    expect_wr(5'd3, 32'h33);
    cyc(2'b10, 5'd3, 32'h0, 32'h33, 1'b1, 5'd13, 32'h1313);
    expect_wr(5'd13, 32'h1313);
    cyc(2'b10, 5'd0, 32'h0, 32'h77, 1'b0, 5'd0, 32'h0);
    idle(1);
    expect_wr(5'd14, 32'hE);
    cyc(2'b10, 5'd14, 32'h0, 32'hE, 1'b1, 5'd14, 32'hBAD);
    idle(3);
    chk("r0_md_ready", 32'(bus.md_ready), 32'd1);

    // Reset mid-operation with a full buffer and stall asserted.
    fill_seq();
    @(negedge clk);
    #1;
    bus.md_valid = 1'b0;
    bus.wb_ctl = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("async_rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("async_rst_wdata", bus.rf_wdata, 32'd0);
    chk("async_rst_stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_md_ready", 32'(bus.md_ready), 32'd1);
    idle(4);
    chk("rst_no_stale_stall", 32'(bus.stall_req), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
